// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared state encodings, data width and counter width helper for the BNN sequencer
package bnn_pkg;

    localparam int BNN_DATA_W = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // Width of a down-counter that must hold n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bnn_seq_timer.sv
// rtl/bnn_seq_timer.sv - loadable down-counter with terminal-count flag
module bnn_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !tc) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/bnn_inference_sequencer.sv
// rtl/bnn_inference_sequencer.sv - batch initiator feeding the BNN core; result timeout enabled by BNN_SEQ_TIMEOUT_EN
module bnn_inference_sequencer
    import bnn_pkg::*;
#(
    parameter int MAX_INPUTS     = 16,
    parameter int DATA_W         = BNN_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDLE_GAP       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [$clog2(MAX_INPUTS):0]   num_inputs,
    output logic                          in_rd_en,
    output logic [$clog2(MAX_INPUTS)-1:0] in_addr,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          bnn_in_valid,
    output logic [DATA_W-1:0]             bnn_in_data,
    input  logic                          bnn_in_ready,
    input  logic                          bnn_out_valid,
    output logic                          start_inference,
    output logic                          inference_done,
    output logic                          busy,
    output logic                          batch_done,
    output logic                          timeout_err,
    output logic [$clog2(MAX_INPUTS):0]   inputs_issued
);

    localparam int AW = $clog2(MAX_INPUTS);
    localparam int CW = AW + 1;
    localparam int GW = cnt_w(IDLE_GAP);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [CW-1:0] idx_nxt;
    logic [CW-1:0] run_cnt;
    logic          last;
    logic          result;
    logic          gap_tc;
    logic          tmo_hit;

    // idx is one bit wider than the address so the final increment never wraps
    assign idx_nxt = idx + CW'(1);
    assign last    = (idx_nxt == cnt);
    assign result  = (state == S_WAIT) && bnn_out_valid;
    assign run_cnt = (num_inputs > CW'(MAX_INPUTS)) ? CW'(MAX_INPUTS) : num_inputs;

    bnn_seq_timer #(.W(GW)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (result && !last),
        .load_val (GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0)),
        .en       (state == S_GAP),
        .tc       (gap_tc)
    );

`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT_CYCLES);

    logic tmo_tc;

    // Loaded on the accept edge so the first WAIT cycle corresponds to elapsed count 0
    bnn_seq_timer #(.W(TW)) u_tmo_timer (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == S_ISSUE) && bnn_in_ready),
        .load_val (TW'(TIMEOUT_CYCLES - 1)),
        .en       (state == S_WAIT),
        .tc       (tmo_tc)
    );

    assign tmo_hit = tmo_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if ((state == S_IDLE) && run) begin
            timeout_err <= 1'b0;
        end else if ((state == S_WAIT) && !bnn_out_valid && tmo_tc) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            idx             <= '0;
            in_rd_en        <= 1'b0;
            in_addr         <= '0;
            bnn_in_valid    <= 1'b0;
            bnn_in_data     <= '0;
            start_inference <= 1'b0;
            inference_done  <= 1'b0;
            busy            <= 1'b0;
            batch_done      <= 1'b0;
            inputs_issued   <= '0;
        end else begin
            in_rd_en        <= 1'b0;
            start_inference <= 1'b0;
            inference_done  <= 1'b0;
            batch_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        cnt           <= run_cnt;
                        idx           <= '0;
                        inputs_issued <= '0;
                        busy          <= 1'b1;
                        if (run_cnt == '0) begin
                            state      <= S_DONE;
                            batch_done <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            in_rd_en <= 1'b1;
                            in_addr  <= '0;
                        end
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    bnn_in_data  <= in_data;
                    bnn_in_valid <= 1'b1;
                    state        <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bnn_in_ready) begin
                        bnn_in_valid    <= 1'b0;
                        inputs_issued   <= inputs_issued + CW'(1);
                        start_inference <= 1'b1;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle takes priority
                    if (bnn_out_valid) begin
                        inference_done <= 1'b1;
                        idx            <= idx_nxt;
                        if (last) begin
                            state      <= S_DONE;
                            batch_done <= 1'b1;
                        end else if (IDLE_GAP == 0) begin
                            state    <= S_FETCH;
                            in_rd_en <= 1'b1;
                            in_addr  <= idx_nxt[AW-1:0];
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (tmo_hit) begin
                        inference_done <= 1'b1;
                        state          <= S_DONE;
                        batch_done     <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_tc) begin
                        state    <= S_FETCH;
                        in_rd_en <= 1'b1;
                        in_addr  <= idx[AW-1:0];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_inference_sequencer.sv
// tb/tb_bnn_inference_sequencer.sv - directed self-checking bench for bnn_inference_sequencer
module tb_bnn_inference_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [4:0]  num_inputs = '0;
    logic        in_rd_en;
    logic [3:0]  in_addr;
    logic [15:0] in_data = '0;
    logic        bnn_in_valid;
    logic [15:0] bnn_in_data;
    logic        bnn_in_ready = 1'b1;
    logic        bnn_out_valid = 1'b0;
    logic        start_inference;
    logic        inference_done;
    logic        busy;
    logic        batch_done;
    logic        timeout_err;
    logic [4:0]  inputs_issued;
    logic [31:0] out_vec;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_rd = 0, n_start = 0, n_done = 0, n_bdone = 0, n_both = 0;
    int done_cyc = -1000;
    int resp_lat = 5;
    int resp_cnt = 0;
    int addr_q[$];
    int gap_q[$];
    int data_q[$];

    bnn_inference_sequencer #(
        .MAX_INPUTS     (16),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (8),
        .IDLE_GAP       (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .num_inputs      (num_inputs),
        .in_rd_en        (in_rd_en),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .bnn_in_valid    (bnn_in_valid),
        .bnn_in_data     (bnn_in_data),
        .bnn_in_ready    (bnn_in_ready),
        .bnn_out_valid   (bnn_out_valid),
        .start_inference (start_inference),
        .inference_done  (inference_done),
        .busy            (busy),
        .batch_done      (batch_done),
        .timeout_err     (timeout_err),
        .inputs_issued   (inputs_issued)
    );

    assign out_vec = {in_rd_en, in_addr, bnn_in_valid, bnn_in_data, start_inference,
                      inference_done, busy, batch_done, timeout_err, inputs_issued};

    always #5 clk = ~clk;

    function automatic logic [15:0] vec_of(input int a);
        return 16'hC000 + 16'(a) * 16'd37;
    endfunction

    // Input buffer: one-cycle read latency, junk when not read
    always @(posedge clk) in_data <= in_rd_en ? vec_of(int'(in_addr)) : 16'hDEAD;

    // Core model: result pulse resp_lat cycles after the accept; 0 means never answer
    always @(negedge clk) begin
        bnn_out_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) bnn_out_valid = 1'b1;
        end
        if (bnn_in_valid && bnn_in_ready) resp_cnt = resp_lat;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (in_rd_en) begin
            n_rd = n_rd + 1;
            addr_q.push_back(int'(in_addr));
            gap_q.push_back(cyc - done_cyc);
        end
        if (bnn_in_valid && bnn_in_ready) data_q.push_back(int'(bnn_in_data));
        if (start_inference) n_start = n_start + 1;
        if (inference_done) begin
            n_done = n_done + 1;
            done_cyc = cyc;
        end
        if (batch_done) n_bdone = n_bdone + 1;
        if (start_inference && inference_done) n_both = n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_batch(input int n, input int bound, output int k);
        num_inputs = 5'(n);
        run = 1'b1;
        tick();
        k = 1;
        run = 1'b0;
        while (!batch_done && k < bound) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int k, qa, qg, qd, b_start, b_done, b_rd, b_bdone;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", out_vec, 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", out_vec, 32'h0);

        // Three inputs, always ready, result 5 cycles after accept
        b_start = n_start; b_done = n_done; b_rd = n_rd; b_bdone = n_bdone;
        qa = addr_q.size(); qg = gap_q.size(); qd = data_q.size();
        run_batch(3, 60, k);
        chk("t1_latency", k, 29);
        chk("t1_bdone_busy", {batch_done, busy}, 2'b11);
        tick();
        chk("t1_busy_low", {busy, batch_done}, 2'b00);
        chk("t1_starts", n_start - b_start, 3);
        chk("t1_dones", n_done - b_done, 3);
        chk("t1_reads", n_rd - b_rd, 3);
        chk("t1_batch_done_cnt", n_bdone - b_bdone, 1);
        chk("t1_issued", inputs_issued, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_addr%0d", i), (qa + i < addr_q.size()) ? addr_q[qa + i] : -1, i);
            chk($sformatf("t1_data%0d", i), (qd + i < data_q.size()) ? data_q[qd + i] : -1,
                int'(vec_of(i)));
        end
        for (int i = 1; i < 3; i++)
            chk($sformatf("t1_gap%0d", i), (qg + i < gap_q.size()) ? gap_q[qg + i] : -1, 2);

        // Empty batch
        b_start = n_start; b_rd = n_rd;
        run_batch(0, 10, k);
        chk("t2_latency", k, 1);
        chk("t2_bdone_busy", {batch_done, busy}, 2'b11);
        tick();
        chk("t2_after", {batch_done, busy}, 2'b00);
        chk("t2_no_reads", n_rd - b_rd, 0);
        chk("t2_no_starts", n_start - b_start, 0);

        // Oversized batch clamps to 16
        b_start = n_start; b_rd = n_rd;
        qa = addr_q.size(); qd = data_q.size();
        run_batch(20, 400, k);
        chk("t3_latency", k, 159);
        tick();
        chk("t3_starts", n_start - b_start, 16);
        chk("t3_reads", n_rd - b_rd, 16);
        chk("t3_issued", inputs_issued, 16);
        chk("t3_last_addr", (addr_q.size() == qa + 16) ? addr_q[qa + 15] : -1, 15);
        chk("t3_last_data", (data_q.size() == qd + 16) ? data_q[qd + 15] : -1, int'(vec_of(15)));

        // Back-pressure: ready low for 7 ISSUE cycles
        bnn_in_ready = 1'b0;
        b_start = n_start;
        num_inputs = 5'd1;
        run = 1'b1;
        tick();
        run = 1'b0;
        k = 0;
        while (!bnn_in_valid && k < 10) begin
            tick();
            k++;
        end
        chk("t4_valid_seen", bnn_in_valid, 1'b1);
        begin
            int unstable = 0;
            for (int i = 0; i < 7; i++) begin
                if (bnn_in_valid !== 1'b1 || bnn_in_data !== vec_of(0) || start_inference !== 1'b0)
                    unstable++;
                tick();
            end
            chk("t4_stable_while_stalled", unstable, 0);
        end
        chk("t4_no_start_before_accept", n_start - b_start, 0);
        bnn_in_ready = 1'b1;
        tick();
        chk("t4_start_after_accept", {start_inference, bnn_in_valid}, 2'b10);
        chk("t4_issued", inputs_issued, 1);
        k = 0;
        while (!batch_done && k < 30) begin
            tick();
            k++;
        end
        chk("t4_batch_done", batch_done, 1'b1);
        tick();

        // Core never answers
        resp_lat = 0;
        b_done = n_done;
        num_inputs = 5'd2;
        run = 1'b1;
        tick();
        run = 1'b0;
        k = 0;
        while (!start_inference && k < 20) begin
            tick();
            k++;
        end
        chk("t5_start_seen", start_inference, 1'b1);
`ifdef BNN_SEQ_TIMEOUT_EN
        k = 0;
        while (!inference_done && k < 40) begin
            tick();
            k++;
        end
        chk("t5_done_after_timeout", k, 8);
        chk("t5_err_bdone", {timeout_err, batch_done}, 2'b11);
        chk("t5_issued", inputs_issued, 1);
        tick();
        chk("t5_err_sticky", {timeout_err, busy}, 2'b10);
        resp_lat = 5;
        num_inputs = 5'd1;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t5_err_cleared", timeout_err, 1'b0);
        k = 0;
        while (!batch_done && k < 40) begin
            tick();
            k++;
        end
        chk("t5_rerun_done", batch_done, 1'b1);
        tick();
`else
        repeat (40) tick();
        chk("t5_still_waiting", {busy, timeout_err, batch_done}, 3'b100);
        chk("t5_no_done", n_done - b_done, 0);
        rst = 1'b1;
        #1;
        chk("t5_reset_outputs", out_vec, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        resp_lat = 5;
`endif

        // Reset in the middle of the third inference
        b_start = n_start;
        num_inputs = 5'd3;
        run = 1'b1;
        tick();
        run = 1'b0;
        k = 0;
        while ((n_start - b_start) < 3 && k < 100) begin
            tick();
            k++;
        end
        chk("t6_third_start", n_start - b_start, 3);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_reset_outputs", out_vec, 32'h0);
        b_done = n_done;
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("t6_no_done_after_reset", n_done - b_done, 0);
        chk("t6_idle", {busy, batch_done}, 2'b00);
        qa = addr_q.size();
        run_batch(1, 30, k);
        chk("t6_rerun_latency", k, 9);
        chk("t6_restart_addr", (addr_q.size() > qa) ? addr_q[qa] : -1, 0);
        chk("t6_issued", inputs_issued, 1);
        tick();

        chk("never_start_and_done", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
